// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for a NUM_DIGITS-digit seven-segment display.
// The displayed word is snapshotted at frame boundaries so a frame never mixes two words.
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           word,
    input  logic                  freeze,
    input  logic                  blank_zeros,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int unsigned CNT_W   = $clog2(REFRESH_DIV);
    localparam int unsigned DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIGIT_W-1:0]    DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]      div_cnt;
    logic [DIGIT_W-1:0]    digit;
    logic [31:0]           snapshot;
    logic                  load_pending;

    logic                  tick;
    logic                  last_digit;
    logic                  load;
    logic [31:0]           disp_data;
    logic [3:0]            nib;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    assign tick       = (div_cnt == CNT_LAST);
    assign last_digit = (digit == DIGIT_LAST);
    assign load       = load_pending || (tick && last_digit && !freeze);

    // The first cycle after reset shows the word being loaded, not the cleared snapshot
    assign disp_data  = load_pending ? word : snapshot;

    // Digit select, one-hot enable and leading-zero blanking for the current digit
    always_comb begin
        nib       = 4'h0;
        an_onehot = '0;
        blank     = blank_zeros && (digit != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == DIGIT_W'(i)) begin
                nib          = disp_data[4*i +: 4];
                an_onehot[i] = 1'b1;
            end
            if ((DIGIT_W'(i) >= digit) && (disp_data[4*i +: 4] != 4'h0)) begin
                blank = 1'b0;
            end
        end
        seg_next = blank ? SEG_OFF : (hex_to_seg(nib) ^ SEG_OFF);
        an_next  = an_onehot ^ AN_OFF;
        dp_next  = ((digit == '0) && freeze) ? ~DP_OFF : DP_OFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            digit        <= '0;
            snapshot     <= '0;
            load_pending <= 1'b1;
            frame_start  <= 1'b0;
            seg          <= SEG_OFF;
            dp           <= DP_OFF;
            an           <= AN_OFF;
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + CNT_W'(1);
            if (tick) begin
                digit <= last_digit ? '0 : digit + DIGIT_W'(1);
            end
            if (load) begin
                snapshot <= word;
            end
            load_pending <= 1'b0;
            frame_start  <= tick && last_digit;
            seg          <= seg_next;
            dp           <= dp_next;
            an           <= an_next;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (REFRESH_DIV=4, 8 digits, active-low outputs).
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word;
    logic        freeze;
    logic        blank_zeros;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_start;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          k           = 0;
    logic [31:0] model_snap  = 32'h0;

    hex_display_scanner #(
        .NUM_DIGITS    (8),
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .word       (word),
        .freeze     (freeze),
        .blank_zeros(blank_zeros),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Expected outputs after clock edge k (k=1 is the first edge after reset release)
    task automatic push_expected();
        exp_t       e;
        int         d;
        logic [3:0] n;
        logic       blk;
        k++;
        if (k == 1) model_snap = word;
        d     = ((k - 1) / 4) % 8;
        n     = model_snap[4*d +: 4];
        blk   = blank_zeros && (d != 0) && ((model_snap >> (4*d)) == 32'd0);
        e.an  = ~(8'(1) << d);
        e.seg = blk ? 7'h7F : ~hex7(n);
        e.dp  = !((d == 0) && freeze);
        e.fs  = ((k % 32) == 0);
        exp_q.push_back(e);
        if (((k % 32) == 0) && !freeze) model_snap = word;
    endtask

    task automatic reset_dut(input logic [31:0] w);
        reset       = 1'b1;
        word        = w;
        freeze      = 1'b0;
        blank_zeros = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        reset       = 1'b1;
        word        = 32'h12345678;
        freeze      = 1'b0;
        blank_zeros = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_held: an=%h seg=%h dp=%b fs=%b, want an=ff seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        exp_q.delete();
        #1;
        vectors++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_pre_clk: an=%h seg=%h dp=%b, want an=ff seg=7f dp=1", an, seg, dp);
        end
        for (int n = 0; n < 8; n++) begin
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL reset_seq k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (n == 0) begin
                vectors++;
                if ({an, seg} !== {8'hFE, 7'h00}) begin
                    miscompares++;
                    $display("FAIL reset_first_digit: an=%h seg=%h, want an=fe seg=00", an, seg);
                end
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int   pulses = 0;
        reset_dut(32'h89ABCDEF);
        for (int n = 0; n < 70; n++) begin
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (frame_start === 1'b1) pulses++;
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL scan k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL scan_frame_pulses: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        reset_dut(32'h11111111);
        for (int n = 0; n < 70; n++) begin
            if (n == 10) word = 32'h22222222;
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL snapshot k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (k == 30 || k == 40) begin
                vectors++;
                if (seg !== ((k == 30) ? 7'h79 : 7'h24)) begin
                    miscompares++;
                    $display("FAIL snapshot_digit k=%0d: seg=%h, want %h", k, seg,
                             (k == 30) ? 7'h79 : 7'h24);
                end
            end
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        reset_dut(32'h0000ABCD);
        for (int n = 0; n < 140; n++) begin
            if (n == 3)   freeze = 1'b1;
            if (n == 5)   word   = 32'hFFFF0000;
            if (n == 110) freeze = 1'b0;
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL freeze k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
    endtask

    task automatic test_blank();
        exp_t e;
        reset_dut(32'h000000A0);
        blank_zeros = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (n == 20) word = 32'h00000000;
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL blank k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
            if (k == 6 || k == 37) begin
                vectors++;
                if ({an, seg} !== {8'hFD, (k == 6) ? 7'h08 : 7'h7F}) begin
                    miscompares++;
                    $display("FAIL blank_digit1 k=%0d: an=%h seg=%h, want an=fd seg=%h", k, an, seg,
                             (k == 6) ? 7'h08 : 7'h7F);
                end
            end
        end
        blank_zeros = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        reset_dut(32'hCAFEF00D);
        for (int n = 0; n < 18; n++) begin
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL midreset_pre k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
        vectors++;
        if (an !== 8'hEF) begin
            miscompares++;
            $display("FAIL midreset_digit4: an=%h, want ef", an);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({an, seg, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_async: an=%h seg=%h dp=%b fs=%b, want an=ff seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        word = 32'h13579BDF;
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            push_expected();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if ({an, seg, dp, frame_start} !== e) begin
                miscompares++;
                $display("FAIL midreset_post k=%0d: an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         k, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_freeze();
        test_blank();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
